// File: rtl/mux_scan.sv
// Registered channel multiplexer with manual select and timed auto-scan.
// Hold freezes channel, dwell counter, FSM and registered outputs.
module mux_scan #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 4,
  localparam int SELW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      resetn,
  input  logic [CHANNELS*WIDTH-1:0] data_in,
  input  logic [SELW-1:0]           sel,
  input  logic                      mode,
  input  logic                      hold,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_ch,
  output logic                      out_valid,
  output logic                      sel_err
);

  localparam int CNTW = $clog2(DWELL + 1);
  localparam int NSLOT = 2 ** SELW;
  localparam logic [SELW:0]   CH_LIM   = (SELW + 1)'(CHANNELS);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);
  localparam logic [CNTW-1:0] CNT_LOAD = CNTW'(DWELL - 1);

  typedef enum logic {MANUAL, SCAN} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [SELW-1:0]   r_ch;
  logic [SELW-1:0]   w_ch_next;
  logic [SELW-1:0]   w_ch_inc;
  logic [CNTW-1:0]   r_cnt;
  logic [CNTW-1:0]   w_cnt_next;
  logic              r_sel_err;
  logic              w_sel_err_next;
  logic [WIDTH-1:0]  r_out_data;
  logic              r_out_valid;
  logic              w_sel_ok;
  logic [WIDTH-1:0]  w_chan [NSLOT];

  // Slots beyond CHANNELS read as zero so every select code has a defined source.
  generate
    for (genvar gi = 0; gi < NSLOT; gi++) begin : g_chan
      if (gi < CHANNELS) begin : g_real
        assign w_chan[gi] = data_in[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign w_chan[gi] = '0;
      end
    end
  endgenerate

  assign w_sel_ok = ({1'b0, sel} < CH_LIM);
  assign w_ch_inc = (r_ch == LAST_CH) ? '0 : r_ch + SELW'(1);

  always_comb begin
    w_state_next   = r_state;
    w_ch_next      = r_ch;
    w_cnt_next     = r_cnt;
    w_sel_err_next = r_sel_err;
    if (!hold) begin
      if (mode) begin
        w_state_next = SCAN;
        if (r_state == MANUAL) begin
          // Entering scan keeps the current channel and starts a full dwell.
          w_cnt_next     = CNT_LOAD;
          w_sel_err_next = 1'b0;
        end else if (r_cnt == '0) begin
          w_ch_next  = w_ch_inc;
          w_cnt_next = CNT_LOAD;
        end else begin
          w_cnt_next = r_cnt - CNTW'(1);
        end
      end else begin
        w_state_next = MANUAL;
        if (w_sel_ok) begin
          w_ch_next      = sel;
          w_sel_err_next = 1'b0;
        end else begin
          w_sel_err_next = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= MANUAL;
      r_ch        <= '0;
      r_cnt       <= CNT_LOAD;
      r_sel_err   <= 1'b0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b1;
      r_state     <= w_state_next;
      r_ch        <= w_ch_next;
      r_cnt       <= w_cnt_next;
      r_sel_err   <= w_sel_err_next;
      if (!hold) begin
        r_out_data <= w_chan[w_ch_next];
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_ch    = r_ch;
  assign out_valid = r_out_valid;
  assign sel_err   = r_sel_err;

endmodule
